// File: rtl/tick_sched_pkg.sv
// Shared constants and FSM encoding for the tick scheduler.
package tick_sched_pkg;

    localparam int IDX_SAMPLE = 0;
    localparam int IDX_FILT   = 1;
    localparam int IDX_ADSR   = 2;
    localparam int NUM_REQ    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_pick.sv
// Fixed-priority one-hot selector; lowest set index wins.
module prio_pick
    import tick_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    // Isolate the lowest set bit.
    always_comb begin
        gnt = req & (~req + NUM_REQ'(1));
    end

endmodule

// File: rtl/tick_sched.sv
// Clock-enable scheduler: phase counter, rate ticks and
// fixed-priority arbitration of one shared arithmetic unit.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int SAMPLE_LOG2 = 9,
    parameter int FILT_LOG2   = 4,
    parameter int ADSR_LOG2   = 18
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 done,
    input  logic                 ovr_clr,
    output logic [NUM_REQ-1:0]   tick,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   overrun,
    output logic [ADSR_LOG2-1:0] phase
);

    localparam int W = ADSR_LOG2;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pend_nxt;
    logic [NUM_REQ-1:0] due;
    logic [NUM_REQ-1:0] fin;
    logic [NUM_REQ-1:0] ovr_evt;
    logic [NUM_REQ-1:0] ovr_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant_nxt;

    always_comb begin
        due             = '0;
        due[IDX_SAMPLE] = &phase[SAMPLE_LOG2-1:0];
        due[IDX_FILT]   = &phase[FILT_LOG2-1:0];
        due[IDX_ADSR]   = &phase[ADSR_LOG2-1:0];
        due             = due & {NUM_REQ{en & ~clr}};
    end

    // A job that completes on the same edge it is re-requested
    // simply stays pending; only an unserved repeat is an overrun.
    always_comb begin
        fin      = (state == ST_GRANT && done) ? grant : '0;
        ovr_evt  = due & pending & ~fin;
        ovr_nxt  = (ovr_clr ? '0 : overrun) | ovr_evt;
        pend_nxt = (pending & ~fin) | due;
        if (clr) begin
            pend_nxt = '0;
        end
    end

    prio_pick u_pick (
        .req (pending),
        .gnt (pick)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        unique case (state)
            ST_IDLE: begin
                if (|pending) begin
                    grant_nxt = pick;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    grant_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
        if (clr) begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            busy  <= |grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase   <= '0;
            tick    <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            if (clr) begin
                phase <= '0;
            end else if (en) begin
                phase <= phase + W'(1);
            end
            tick    <= due;
            pending <= pend_nxt;
            overrun <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched with a
// period-counting reference model.
module tb_tick_sched;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       done = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [2:0] tick;
    logic [2:0] grant;
    logic       busy;
    logic [2:0] overrun;
    logic [3:0] phase;
    logic [13:0] obs;

    int errors = 0;
    int checks = 0;

    // model: enabled-edge count, pending set, owner index
    int       m_cnt;
    bit [2:0] m_tick;
    bit [2:0] m_pend;
    bit [2:0] m_ovr;
    int       m_own;
    int       per [3] = '{8, 4, 16};

    tick_sched #(
        .SAMPLE_LOG2 (3),
        .FILT_LOG2   (2),
        .ADSR_LOG2   (4)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .en      (en),
        .clr     (clr),
        .done    (done),
        .ovr_clr (ovr_clr),
        .tick    (tick),
        .grant   (grant),
        .busy    (busy),
        .overrun (overrun),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    assign obs = {tick, grant, busy, overrun, phase};

    task automatic m_reset();
        m_cnt  = 0;
        m_tick = '0;
        m_pend = '0;
        m_ovr  = '0;
        m_own  = -1;
    endtask

    function automatic logic [13:0] exp_vec();
        logic [2:0] g;
        g = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        return {m_tick, g, m_own >= 0, m_ovr, 4'(m_cnt)};
    endfunction

    // Advance one clock edge; model follows the rate rules.
    task automatic cycle();
        bit [2:0] due;
        bit [2:0] np;
        bit [2:0] no;
        int       nown;
        int       ncnt;
        bit       fin;
        fin = (m_own >= 0) && done;
        for (int i = 0; i < 3; i++)
            due[i] = en && !clr && ((m_cnt + 1) % per[i] == 0);
        np = m_pend;
        if (fin) np[m_own] = 1'b0;
        no = ovr_clr ? 3'b000 : m_ovr;
        for (int i = 0; i < 3; i++) begin
            if (due[i]) begin
                if (m_pend[i] && !(fin && m_own == i)) no[i] = 1'b1;
                np[i] = 1'b1;
            end
        end
        nown = m_own;
        if (m_own >= 0) begin
            if (done) nown = -1;
        end else begin
            for (int i = 2; i >= 0; i--)
                if (m_pend[i]) nown = i;
        end
        ncnt = clr ? 0 : (en ? (m_cnt + 1) % 16 : m_cnt);
        if (clr) begin
            np   = '0;
            nown = -1;
        end
        @(posedge clk);
        #1;
        if (!arst_n) begin
            m_reset();
        end else begin
            m_cnt  = ncnt;
            m_tick = due;
            m_pend = np;
            m_ovr  = no;
            m_own  = nown;
        end
    endtask

    task automatic do_reset();
        en      = 1'b0;
        clr     = 1'b0;
        done    = 1'b0;
        ovr_clr = 1'b0;
        arst_n  = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 1'b1;
        #2;
        arst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs !== 14'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0", obs);
        end
        do_reset();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_periodic();
        int n0 = 0, n1 = 0, n2 = 0, first1 = -1, last1 = 0;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            done = busy;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL per_model k=%0d: got %b want %b", k, obs, exp_vec());
            end
            if (tick[0]) n0++;
            if (tick[2]) n2++;
            if (tick[1]) begin
                n1++;
                if (first1 < 0) first1 = k;
                else begin
                    checks++;
                    if (k - last1 != 4) begin
                        errors++;
                        $display("FAIL per_gap1: got %0d want 4", k - last1);
                    end
                end
                last1 = k;
            end
            if (k == 15 || k == 16) begin
                checks++;
                if (phase !== 4'(k)) begin
                    errors++;
                    $display("FAIL per_wrap: got %0d want %0d", phase, k % 16);
                end
            end
        end
        checks++;
        if (first1 != 4) begin
            errors++;
            $display("FAIL per_first1: got %0d want 4", first1);
        end
        checks++;
        if ({n0, n1, n2} != {32'd4, 32'd8, 32'd2}) begin
            errors++;
            $display("FAIL per_counts: got %0d/%0d/%0d want 4/8/2", n0, n1, n2);
        end
        checks++;
        if (overrun !== 3'b000) begin
            errors++;
            $display("FAIL per_ovr: got %b want 000", overrun);
        end
        done = 1'b0;
    endtask

    task automatic test_coincide();
        logic [2:0] seq [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        logic [2:0] chg [$];
        logic [2:0] last, base;
        bit         hit = 1'b0;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 40 && !hit; k++) begin
            done = busy;
            cycle();
            if (tick === 3'b111) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL coin_tick: got no 111 want 111");
        end
        last = grant;
        base = grant;
        for (int j = 0; j < 12; j++) begin
            done = (grant != 3'b000) && (grant == last);
            last = grant;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL coin_model: got %b want %b", obs, exp_vec());
            end
            if (grant !== base) begin
                chg.push_back(grant);
                base = grant;
            end
        end
        checks++;
        if (chg.size() < 6) begin
            errors++;
            $display("FAIL coin_len: got %0d want >=6", chg.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (chg[j] !== seq[j]) begin
                    errors++;
                    $display("FAIL coin_seq%0d: got %b want %b", j, chg[j], seq[j]);
                end
            end
        end
        done = 1'b0;
    endtask

    task automatic test_overrun();
        bit hit = 1'b0;
        int rise [3] = '{0, 0, 0};
        logic [2:0] prev;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 30 && !hit; k++) begin
            done = busy;
            cycle();
            if (grant === 3'b001) hit = 1'b1;
        end
        done = 1'b0;
        hit  = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            cycle();
            if (overrun !== 3'b000) hit = 1'b1;
        end
        checks++;
        if (overrun !== 3'b010 || grant !== 3'b001) begin
            errors++;
            $display("FAIL ovr_set: got %b/%b want 010/001", overrun, grant);
        end
        en      = 1'b0;
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 3'b000) begin
            errors++;
            $display("FAIL ovr_clr: got %b want 000", overrun);
        end
        done = 1'b1;
        cycle();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL ovr_done: got %b want 000", grant);
        end
        prev = grant;
        for (int k = 0; k < 10; k++) begin
            done = busy;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL ovr_model: got %b want %b", obs, exp_vec());
            end
            for (int i = 0; i < 3; i++)
                if (grant[i] && !prev[i]) rise[i]++;
            prev = grant;
        end
        checks++;
        if (rise[0] != 0 || rise[1] != 1 || rise[2] != 0) begin
            errors++;
            $display("FAIL ovr_grants: got %0d/%0d/%0d want 0/1/0", rise[0], rise[1], rise[2]);
        end
        done = 1'b0;
    endtask

    task automatic test_freeze();
        logic [2:0] seq [4] = '{3'b001, 3'b000, 3'b100, 3'b000};
        logic [2:0] chg [$];
        logic [2:0] last, base;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 16; k++) cycle();
        checks++;
        if (grant !== 3'b010 || phase !== 4'd0) begin
            errors++;
            $display("FAIL frz_pre: got %b/%0d want 010/0", grant, phase);
        end
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if (phase !== 4'd0 || tick !== 3'b000 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL frz_hold: got %b want %b", obs, exp_vec());
            end
        end
        done = 1'b1;
        cycle();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL frz_done: got %b want 000", grant);
        end
        last = grant;
        base = grant;
        for (int j = 0; j < 12; j++) begin
            done = (grant != 3'b000) && (grant == last);
            last = grant;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL frz_model: got %b want %b", obs, exp_vec());
            end
            if (grant !== base) begin
                chg.push_back(grant);
                base = grant;
            end
        end
        checks++;
        if (chg.size() != 4) begin
            errors++;
            $display("FAIL frz_len: got %0d want 4", chg.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (chg[j] !== seq[j]) begin
                    errors++;
                    $display("FAIL frz_seq%0d: got %b want %b", j, chg[j], seq[j]);
                end
            end
        end
        done = 1'b0;
    endtask

    task automatic test_clear();
        logic [2:0] last;
        bit hit = 1'b0;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ovr_clr = (k == 13);
            done    = (k == 15);
            cycle();
        end
        ovr_clr = 1'b0;
        done    = 1'b0;
        en      = 1'b0;
        checks++;
        if (overrun !== 3'b001 || grant !== 3'b000) begin
            errors++;
            $display("FAIL clr_pre: got %b/%b want 001/000", overrun, grant);
        end
        last = grant;
        for (int k = 0; k < 20 && !hit; k++) begin
            done = (grant != 3'b000) && (grant == last);
            last = grant;
            cycle();
            if (grant === 3'b100) hit = 1'b1;
        end
        done = 1'b0;
        en   = 1'b1;
        cycle();
        cycle();
        checks++;
        if (grant !== 3'b100 || phase !== 4'd2) begin
            errors++;
            $display("FAIL clr_mid: got %b/%0d want 100/2", grant, phase);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        en  = 1'b0;
        checks++;
        if ({grant, phase, overrun} !== {3'b000, 4'd0, 3'b001}) begin
            errors++;
            $display("FAIL clr_after: got %b/%0d/%b want 000/0/001", grant, phase, overrun);
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (grant !== 3'b000 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL clr_idle: got %b want %b", obs, exp_vec());
            end
        end
    endtask

    task automatic test_async();
        int first1 = -1;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL async_pre: got %b want 010", grant);
        end
        #2;
        arst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs !== 14'b0) begin
            errors++;
            $display("FAIL async_zero: got %b want 0", obs);
        end
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            done = busy;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL async_model: got %b want %b", obs, exp_vec());
            end
            if (tick[1] && first1 < 0) first1 = k;
        end
        checks++;
        if (first1 != 4) begin
            errors++;
            $display("FAIL async_first1: got %0d want 4", first1);
        end
        done = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            en      = ($urandom_range(0, 9) != 0);
            done    = ($urandom_range(0, 2) == 0);
            ovr_clr = ($urandom_range(0, 15) == 0);
            clr     = ($urandom_range(0, 49) == 0);
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rnd_model k=%0d: got %b want %b", k, obs, exp_vec());
            end
        end
        en      = 1'b0;
        done    = 1'b0;
        ovr_clr = 1'b0;
        clr     = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_periodic();
        test_coincide();
        test_overrun();
        test_freeze();
        test_clear();
        test_async();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
